adc_scan_ctrl: RTL

ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

---
 rtl/adc_scan_pkg.sv | 58 +++++
 rtl/adc_scan_ctrl_if.sv | 24 ++
 rtl/adc_sclk_gen.sv | 38 +++
 rtl/adc_scan_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/adc_scan_pkg.sv
// ADC scan controller shared types, frame constants and channel helpers.
// ADC_SCAN_CONT_EN is the optional feature macro used by adc_scan_ctrl.
package adc_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  localparam int FRAME_SCLK = 19;
  localparam int DATA_FIRST = 7;
  localparam int DATA_LAST  = 18;
  localparam int CH_W       = 3;
  localparam int DATA_W     = DATA_LAST - DATA_FIRST + 1;
  localparam int NCH        = 1 << CH_W;
  localparam int PER_W      = $clog2(FRAME_SCLK);

  typedef struct packed {
    logic            hit;
    logic [CH_W-1:0] ch;
  } ch_pick_t;

  // Lowest set mask bit at or above lo; lo == NCH finds nothing.
  function automatic ch_pick_t pick_ch(
    input logic [NCH-1:0] mask,
    input logic [CH_W:0]  lo
  );
    ch_pick_t p;
    p = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(lo))) begin
        p.hit = 1'b1;
        p.ch  = CH_W'(i);
      end
    end
    return p;
  endfunction

  // Command: start, single-ended, D2, D1, D0, then zeros.
  function automatic logic cmd_bit(
    input logic [PER_W-1:0] per,
    input logic [CH_W-1:0]  ch
  );
    logic b;
    case (per)
      PER_W'(0): b = 1'b1;
      PER_W'(1): b = 1'b1;
      PER_W'(2): b = ch[2];
      PER_W'(3): b = ch[1];
      PER_W'(4): b = ch[0];
      default:   b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/adc_scan_ctrl_if.sv
// Serial bus between the scan controller and the ADC.
// The controller owns cs/sclk/din; the ADC returns dout.
interface adc_scan_ctrl_if;

  logic ad_cs;
  logic ad_sclk;
  logic ad_din;
  logic ad_dout;

  modport master (
    output ad_cs,
    output ad_sclk,
    output ad_din,
    input  ad_dout
  );

  modport slave (
    input  ad_cs,
    input  ad_sclk,
    input  ad_din,
    output ad_dout
  );

endinterface

// File: rtl/adc_sclk_gen.sv
// Serial clock generator: CLK_DIV system clocks per half-period.
// Held low while disabled; strobes mark the clock producing each edge.
module adc_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = en && (cnt == CW'(CLK_DIV - 1));
  assign rise = wrap && !sclk;
  assign fall = wrap && sclk;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Multi-channel serial ADC scan controller, one 19-sclk frame per channel.
// Define ADC_SCAN_CONT_EN to add the continuous re-scan input.
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int HOLD_CYC = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [NCH-1:0]      ch_mask,
`ifdef ADC_SCAN_CONT_EN
  input  logic                continuous,
`endif
  adc_scan_ctrl_if.master     adc,
  output logic [DATA_W-1:0]   result_data,
  output logic [CH_W-1:0]     result_ch,
  output logic                result_valid,
  output logic                busy
);

  localparam int TMAX = (CLK_DIV > HOLD_CYC) ? CLK_DIV : HOLD_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  state_t             state;
  logic [NCH-1:0]     mask;
  logic [CH_W-1:0]    ch;
  logic [TW-1:0]      tcnt;
  logic [PER_W-1:0]   per;
  logic [DATA_W-1:0]  sh;
  logic               cs;
  logic               din;
  logic               sclk;
  logic               rise;
  logic               fall;
  ch_pick_t           first;
  ch_pick_t           nxt;
`ifdef ADC_SCAN_CONT_EN
  ch_pick_t           again;
`endif

  assign first = pick_ch(ch_mask, '0);
  assign nxt   = pick_ch(mask, {1'b0, ch} + 1'b1);
`ifdef ADC_SCAN_CONT_EN
  assign again = pick_ch(mask, '0);
`endif

  assign adc.ad_cs   = cs;
  assign adc.ad_din  = din;
  assign adc.ad_sclk = sclk;

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk (
    .clock (clock),
    .reset (reset),
    .en    (state == SHIFT),
    .sclk  (sclk),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      mask         <= '0;
      ch           <= '0;
      tcnt         <= '0;
      per          <= '0;
      sh           <= '0;
      cs           <= 1'b1;
      din          <= 1'b0;
      result_data  <= '0;
      result_ch    <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && first.hit) begin
            mask  <= ch_mask;
            ch    <= first.ch;
            busy  <= 1'b1;
            cs    <= 1'b0;
            din   <= cmd_bit('0, first.ch);
            tcnt  <= '0;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (tcnt == TW'(CLK_DIV - 1)) begin
            per   <= '0;
            state <= SHIFT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        SHIFT: begin
          if (rise && (per >= PER_W'(DATA_FIRST)))
            sh <= {sh[DATA_W-2:0], adc.ad_dout};
          // din moves on the falling edge, ready for the next rise
          if (fall) begin
            if (per == PER_W'(FRAME_SCLK - 1)) begin
              cs           <= 1'b1;
              din          <= 1'b0;
              result_valid <= 1'b1;
              result_data  <= sh;
              result_ch    <= ch;
              tcnt         <= '0;
              state        <= HOLD;
            end else begin
              per <= per + 1'b1;
              din <= cmd_bit(per + 1'b1, ch);
            end
          end
        end
        HOLD: begin
          if (tcnt == TW'(HOLD_CYC - 1)) begin
            tcnt <= '0;
            if (nxt.hit) begin
              ch    <= nxt.ch;
              cs    <= 1'b0;
              din   <= cmd_bit('0, nxt.ch);
              state <= SETUP;
            end else begin
`ifdef ADC_SCAN_CONT_EN
              if (continuous) begin
                ch    <= again.ch;
                cs    <= 1'b0;
                din   <= cmd_bit('0, again.ch);
                state <= SETUP;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
`else
              busy  <= 1'b0;
              state <= IDLE;
`endif
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
